// File: rtl/if_id_latch_if.sv
// Signal bundle between fetch/hazard logic and the IF/ID pipeline latch.
// The latch takes the slave side; the fetch stage and hazard unit take the master side.
interface if_id_latch_if;
  logic        ihit;
  logic [31:0] imemload;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        flush;

  logic [31:0] instr_IF_ID;
  logic [31:0] pc_plus4_IF_ID;
  logic        valid_IF_ID;
  logic [5:0]  opcode_IF_ID;
  logic [5:0]  func_IF_ID;
  logic [4:0]  rs_IF_ID;
  logic [4:0]  rt_IF_ID;
  logic [4:0]  rd_IF_ID;
  logic [4:0]  shamt_IF_ID;
  logic [15:0] imm16_IF_ID;
  logic        halt_IF_ID;
  logic        pc_en;
  logic        fetch_ready;

  modport slave (
    input  ihit, imemload, pc_plus4, stall, flush,
    output instr_IF_ID, pc_plus4_IF_ID, valid_IF_ID, opcode_IF_ID, func_IF_ID,
           rs_IF_ID, rt_IF_ID, rd_IF_ID, shamt_IF_ID, imm16_IF_ID, halt_IF_ID,
           pc_en, fetch_ready
  );

  modport master (
    output ihit, imemload, pc_plus4, stall, flush,
    input  instr_IF_ID, pc_plus4_IF_ID, valid_IF_ID, opcode_IF_ID, func_IF_ID,
           rs_IF_ID, rt_IF_ID, rd_IF_ID, shamt_IF_ID, imm16_IF_ID, halt_IF_ID,
           pc_en, fetch_ready
  );
endinterface

// File: rtl/if_id_latch.sv
// IF/ID pipeline register with a one-entry skid buffer for fetches that land
// during a stall, and a halt state that freezes the latch until a flush.
module if_id_latch #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input logic          CLK,
  input logic          RST,
  if_id_latch_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BUFFERED = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_skid_valid;
  logic        w_load_halt;
  logic        w_skid_halt;

  assign w_load_halt = (bus.imemload[31:26] == HALT_OP);
  assign w_skid_halt = r_skid_valid && (r_skid_instr[31:26] == HALT_OP);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (bus.flush)                    w_state_next = ST_RUN;
        else if (bus.stall)               w_state_next = bus.ihit ? ST_BUFFERED : ST_RUN;
        else if (bus.ihit && w_load_halt) w_state_next = ST_HALTED;
      end
      ST_BUFFERED: begin
        if (bus.flush)       w_state_next = ST_RUN;
        else if (!bus.stall) w_state_next = w_skid_halt ? ST_HALTED : ST_RUN;
      end
      ST_HALTED: begin
        if (bus.flush) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    bus.fetch_ready = (r_state == ST_RUN);
    bus.pc_en       = (r_state == ST_RUN) && bus.ihit && !bus.stall;
  end

  // Datapath: pipeline register and skid buffer, priority RST > flush > stall > load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_instr      <= NOP_WORD;
      r_pc_plus4   <= '0;
      r_valid      <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_valid <= 1'b0;
    end else if (bus.flush) begin
      r_instr      <= NOP_WORD;
      r_pc_plus4   <= '0;
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.stall) begin
            if (bus.ihit) begin
              r_skid_instr <= bus.imemload;
              r_skid_pc    <= bus.pc_plus4;
              r_skid_valid <= 1'b1;
            end
          end else if (bus.ihit) begin
            r_instr    <= bus.imemload;
            r_pc_plus4 <= bus.pc_plus4;
            r_valid    <= 1'b1;
          end else begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
          end
        end
        ST_BUFFERED: begin
          if (!bus.stall) begin
            r_instr      <= r_skid_instr;
            r_pc_plus4   <= r_skid_pc;
            r_valid      <= r_skid_valid;
            r_skid_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_IF_ID    = r_instr;
  assign bus.pc_plus4_IF_ID = r_pc_plus4;
  assign bus.valid_IF_ID    = r_valid;
  assign bus.opcode_IF_ID   = r_instr[31:26];
  assign bus.rs_IF_ID       = r_instr[25:21];
  assign bus.rt_IF_ID       = r_instr[20:16];
  assign bus.rd_IF_ID       = r_instr[15:11];
  assign bus.shamt_IF_ID    = r_instr[10:6];
  assign bus.func_IF_ID     = r_instr[5:0];
  assign bus.imm16_IF_ID    = r_instr[15:0];
  assign bus.halt_IF_ID     = r_valid && (r_instr[31:26] == HALT_OP);

endmodule

// File: tb/tb_if_id_latch.sv
// Self-checking bench for if_id_latch: each cycle's expected registered outputs
// are queued when the stimulus is driven and compared just after the clock edge.
module tb_if_id_latch;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } exp_t;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  if_id_latch_if bus ();

  if_id_latch #(
    .NOP_WORD (32'h0000_0000),
    .HALT_OP  (6'b111111)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard monitor: registered outputs are stable 2 time units after the edge.
  always @(posedge CLK) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (bus.instr_IF_ID !== e.instr || bus.pc_plus4_IF_ID !== e.pc || bus.valid_IF_ID !== e.valid) begin
        n_errors++;
        $display("FAIL sb_out: got instr=%h pc=%h valid=%b, expected instr=%h pc=%h valid=%b",
                 bus.instr_IF_ID, bus.pc_plus4_IF_ID, bus.valid_IF_ID, e.instr, e.pc, e.valid);
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
  task automatic drive(input logic rst, input logic ihit, input logic [31:0] imem,
                       input logic [31:0] pc, input logic stall, input logic flush,
                       input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_valid);
    exp_t e;
    @(negedge CLK);
    RST          = rst;
    bus.ihit     = ihit;
    bus.imemload = imem;
    bus.pc_plus4 = pc;
    bus.stall    = stall;
    bus.flush    = flush;
    e.instr = e_instr;
    e.pc    = e_pc;
    e.valid = e_valid;
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    // State is RUN after reset; stall blocks pc_en even with ihit
    n_checks++;
    if (bus.fetch_ready !== 1'b1 || bus.pc_en !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready: fetch_ready=%b pc_en=%b, expected 1 0", bus.fetch_ready, bus.pc_en);
    end
    bus.stall = 1'b0;
    #1;
    n_checks++;
    if (bus.pc_en !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_pc_en: pc_en=%b, expected 1", bus.pc_en);
    end
    bus.ihit = 1'b0;
    #1;
    n_checks++;
    if (bus.pc_en !== 1'b0 || bus.halt_IF_ID !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: pc_en=%b halt=%b, expected 0 0", bus.pc_en, bus.halt_IF_ID);
    end
  endtask

  task automatic test_stream();
    drive(1'b0, 1'b1, 32'h2008_0005, 32'h4, 1'b0, 1'b0, 32'h2008_0005, 32'h4, 1'b1);
    n_checks++;
    if (bus.pc_en !== 1'b1) begin
      n_errors++;
      $display("FAIL stream_pc_en: pc_en=%b, expected 1", bus.pc_en);
    end
    drive(1'b0, 1'b1, 32'h0109_5020, 32'h8, 1'b0, 1'b0, 32'h0109_5020, 32'h8, 1'b1);
    // Outputs currently show 2008_0005 (addi $t0, $zero, 5)
    n_checks++;
    if (bus.opcode_IF_ID !== 6'h08 || bus.rs_IF_ID !== 5'd0 || bus.rt_IF_ID !== 5'd8 ||
        bus.imm16_IF_ID !== 16'h0005 || bus.halt_IF_ID !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_fields: op=%h rs=%0d rt=%0d imm=%h halt=%b, expected 08 0 8 0005 0",
               bus.opcode_IF_ID, bus.rs_IF_ID, bus.rt_IF_ID, bus.imm16_IF_ID, bus.halt_IF_ID);
    end
    drive(1'b0, 1'b1, 32'h0000_0000, 32'hC, 1'b0, 1'b0, 32'h0000_0000, 32'hC, 1'b1);
    // Outputs show 0109_5020 (add $t2, $t0, $t1)
    n_checks++;
    if (bus.rs_IF_ID !== 5'd8 || bus.rt_IF_ID !== 5'd9 || bus.rd_IF_ID !== 5'd10 ||
        bus.shamt_IF_ID !== 5'd0 || bus.func_IF_ID !== 6'h20) begin
      n_errors++;
      $display("FAIL stream_rtype: rs=%0d rt=%0d rd=%0d sh=%0d fn=%h, expected 8 9 10 0 20",
               bus.rs_IF_ID, bus.rt_IF_ID, bus.rd_IF_ID, bus.shamt_IF_ID, bus.func_IF_ID);
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 1'b0, 32'h1234_5678, 32'h99, 1'b0, 1'b0, 32'h0, 32'hC, 1'b0);
    n_checks++;
    if (bus.pc_en !== 1'b0 || bus.fetch_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bubble_ctrl: pc_en=%b fetch_ready=%b, expected 0 1", bus.pc_en, bus.fetch_ready);
    end
  endtask

  task automatic test_skid();
    drive(1'b0, 1'b1, 32'h00A5_3020, 32'h10, 1'b0, 1'b0, 32'h00A5_3020, 32'h10, 1'b1);
    drive(1'b0, 1'b1, 32'h8C22_0004, 32'h14, 1'b1, 1'b0, 32'h00A5_3020, 32'h10, 1'b1);
    n_checks++;
    if (bus.pc_en !== 1'b0) begin
      n_errors++;
      $display("FAIL skid_pc_en: pc_en=%b, expected 0", bus.pc_en);
    end
    // Second fetch while buffered must never be captured
    drive(1'b0, 1'b1, 32'h1234_5678, 32'h18, 1'b1, 1'b0, 32'h00A5_3020, 32'h10, 1'b1);
    n_checks++;
    if (bus.fetch_ready !== 1'b0 || bus.pc_en !== 1'b0) begin
      n_errors++;
      $display("FAIL skid_blocked: fetch_ready=%b pc_en=%b, expected 0 0", bus.fetch_ready, bus.pc_en);
    end
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1C, 1'b0, 1'b0, 32'h8C22_0004, 32'h14, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8C22_0004, 32'h14, 1'b1);
    n_checks++;
    if (bus.fetch_ready !== 1'b1 || bus.opcode_IF_ID !== 6'h23 || bus.rs_IF_ID !== 5'd1 ||
        bus.rt_IF_ID !== 5'd2) begin
      n_errors++;
      $display("FAIL skid_release: fetch_ready=%b op=%h rs=%0d rt=%0d, expected 1 23 1 2",
               bus.fetch_ready, bus.opcode_IF_ID, bus.rs_IF_ID, bus.rt_IF_ID);
    end
  endtask

  task automatic test_flush_priority();
    drive(1'b0, 1'b1, 32'h1111_1111, 32'h20, 1'b1, 1'b0, 32'h8C22_0004, 32'h14, 1'b1);
    drive(1'b0, 1'b1, 32'h2222_2222, 32'h24, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (bus.fetch_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_state: fetch_ready=%b, expected 1", bus.fetch_ready);
    end
    // Flush in RUN beats a simultaneous fetch
    drive(1'b0, 1'b1, 32'h3333_3333, 32'h28, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_halt();
    logic [31:0] w;
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h40, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h40, 1'b1);
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      drive(1'b0, 1'(i % 2), w, 32'h44 + 32'(4 * i), 1'(i % 3 == 0), 1'b0,
            32'hFFFF_FFFF, 32'h40, 1'b1);
      if (i == 1) begin
        n_checks++;
        if (bus.halt_IF_ID !== 1'b1 || bus.pc_en !== 1'b0 || bus.fetch_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL halt_ctrl: halt=%b pc_en=%b fetch_ready=%b, expected 1 0 0",
                   bus.halt_IF_ID, bus.pc_en, bus.fetch_ready);
        end
      end
    end
    drive(1'b0, 1'b1, 32'h5555_5555, 32'h80, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (bus.fetch_ready !== 1'b1 || bus.halt_IF_ID !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_flush: fetch_ready=%b halt=%b, expected 1 0", bus.fetch_ready, bus.halt_IF_ID);
    end
    // Halt arriving through the skid buffer
    drive(1'b0, 1'b1, 32'hFC00_0000, 32'h90, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFC00_0000, 32'h90, 1'b1);
    drive(1'b0, 1'b1, 32'h6666_6666, 32'h94, 1'b0, 1'b0, 32'hFC00_0000, 32'h90, 1'b1);
    n_checks++;
    if (bus.halt_IF_ID !== 1'b1 || bus.fetch_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_skid: halt=%b fetch_ready=%b, expected 1 0", bus.halt_IF_ID, bus.fetch_ready);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 32'h0AAA_0001, 32'h50, 1'b0, 1'b0, 32'h0AAA_0001, 32'h50, 1'b1);
    drive(1'b0, 1'b1, 32'h0BBB_0002, 32'h54, 1'b1, 1'b0, 32'h0AAA_0001, 32'h50, 1'b1);
    drive(1'b1, 1'b1, 32'h0CCC_0003, 32'h58, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (bus.fetch_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_state: fetch_ready=%b, expected 1", bus.fetch_ready);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    // Reset during HALTED
    drive(1'b0, 1'b1, 32'hFFFF_0000, 32'h60, 1'b0, 1'b0, 32'hFFFF_0000, 32'h60, 1'b1);
    drive(1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (bus.fetch_ready !== 1'b1 || bus.halt_IF_ID !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_halt: fetch_ready=%b halt=%b, expected 1 0", bus.fetch_ready, bus.halt_IF_ID);
    end
  endtask

  initial begin
    int budget;
    n_checks     = 0;
    n_errors     = 0;
    RST          = 1'b1;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.pc_plus4 = '0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;

    test_reset();
    test_stream();
    test_bubble();
    test_skid();
    test_flush_priority();
    test_halt();
    test_reset_mid();

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(negedge CLK);
      budget++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
